// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and the frame state enum.
// Used by the transmitter and the planned parametrised receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; rd_data shows the head word.
// Ports: clk, rst (async active-low), wr_en/wr_data, rd_en/rd_data, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr)
             - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO, baud counter, framing FSM, parity.
// Ports: clk, rst (async active-low), tx_val/tx_data in, tx_rdy, overflow, fifo_count, tx, busy out.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_val,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_rdy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx,
  output logic                          busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 rdy_q, rdy_d;
  logic                 ovf_q, ovf_d;

  logic                 push, pop;
  logic                 full, empty;
  logic [DATA_BITS-1:0] head;
  logic [CW-1:0]        cnt_next;
  logic                 tc;
  logic                 par_nx;

  // A refused write is decided on the pre-edge full flag, so a
  // simultaneous pop never lets a write slip in.
  assign push = tx_val & ~full;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign tc       = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign cnt_next = fifo_count + CW'(push) - CW'(pop);
  assign rdy_d    = (cnt_next != CW'(FIFO_DEPTH));
  assign ovf_d    = tx_val & full;

  // tx_d always carries the level of the bit that starts on this
  // edge, so the line comes straight from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    par_nx  = par_q ^ sh_q[0];
    if (state_q != ST_IDLE) begin
      baud_d = tc ? '0 : baud_q + BW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          baud_d  = '0;
          par_d   = 1'b0;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tc) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      ST_DATA: begin
        if (tc) begin
          par_d = par_nx;
          sh_d  = sh_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PAR;
              tx_d    = (PARITY == PAR_ODD) ? ~par_nx : par_nx;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = sh_q[1];
          end
        end
      end
      ST_PAR: begin
        if (tc) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tc) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            if (!empty) begin
              pop     = 1'b1;
              sh_d    = head;
              par_d   = 1'b0;
              state_d = ST_START;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_rdy   = rdy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations sharing clk/rst.
// Checks framing, parity, back-to-back flow, overflow and reset.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       val [4];
  logic [7:0] dat [4];
  logic       rdy [4];
  logic       ovf [4];
  logic       txl [4];
  logic       bsy [4];
  logic [4:0] cnt [4];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_n8 (
    .clk(clk), .rst(rst), .tx_val(val[0]), .tx_data(dat[0]),
    .tx_rdy(rdy[0]), .overflow(ovf[0]), .fifo_count(cnt[0]),
    .tx(txl[0]), .busy(bsy[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_e8 (
    .clk(clk), .rst(rst), .tx_val(val[1]), .tx_data(dat[1]),
    .tx_rdy(rdy[1]), .overflow(ovf[1]), .fifo_count(cnt[1]),
    .tx(txl[1]), .busy(bsy[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_o8 (
    .clk(clk), .rst(rst), .tx_val(val[2]), .tx_data(dat[2]),
    .tx_rdy(rdy[2]), .overflow(ovf[2]), .fifo_count(cnt[2]),
    .tx(txl[2]), .busy(bsy[2]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u_o7 (
    .clk(clk), .rst(rst), .tx_val(val[3]), .tx_data(dat[3][6:0]),
    .tx_rdy(rdy[3]), .overflow(ovf[3]), .fifo_count(cnt[3]),
    .tx(txl[3]), .busy(bsy[3]));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d);
    @(negedge clk);
    val[k] = 1'b1;
    dat[k] = d;
    @(negedge clk);
    val[k] = 1'b0;
  endtask

  // Called right after send(); bits[0] is the start bit.
  task automatic frame_chk(input int k, input logic [15:0] bits,
                           input int n, input string tag);
    chk({tag, "_pre_busy"}, 32'(bsy[k]), 0);
    chk({tag, "_pre_tx"}, 32'(txl[k]), 1);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk({tag, "_tx"}, 32'(txl[k]), 32'(bits[b]));
        chk({tag, "_busy"}, 32'(bsy[k]), 1);
      end
    end
    @(negedge clk);
    chk({tag, "_end_busy"}, 32'(bsy[k]), 0);
    chk({tag, "_end_tx"}, 32'(txl[k]), 1);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_tx"}, 32'(txl[0]), 1);
    chk({tag, "_busy"}, 32'(bsy[0]), 0);
    chk({tag, "_rdy"}, 32'(rdy[0]), 1);
    chk({tag, "_cnt"}, 32'(cnt[0]), 0);
    chk({tag, "_ovf"}, 32'(ovf[0]), 0);
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      val[k] = 1'b0;
      dat[k] = 8'h00;
    end
    repeat (2) @(negedge clk);
    reset_chk("por");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    reset_chk("rst_idle");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 8'hAC);
    frame_chk(0, 16'({1'b1, 8'hAC, 1'b0}), 10, "n8_ac");

    send(1, 8'hAC);
    frame_chk(1, 16'({1'b1, 1'b0, 8'hAC, 1'b0}), 11, "e8_ac");

    send(2, 8'hAC);
    frame_chk(2, 16'({1'b1, 1'b1, 8'hAC, 1'b0}), 11, "o8_ac");

    send(3, 8'h55);
    frame_chk(3, 16'({2'b11, 1'b1, 7'h55, 1'b0}), 11, "o7_55");

    // 18 writes on consecutive cycles; frame 0 carries word 0x00.
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      val[0] = 1'b1;
      dat[0] = 8'(i);
      @(negedge clk);
      chk("b2b_rdy", 32'(rdy[0]), (i >= 16) ? 0 : 1);
      chk("b2b_ovf", 32'(ovf[0]), (i == 17) ? 1 : 0);
      chk("b2b_cnt", 32'(cnt[0]),
          (i == 0) ? 1 : ((i > 16) ? 16 : i));
      if (i > 0) begin
        chk("b2b_tx0", 32'(txl[0]), 0);
        chk("b2b_busy0", 32'(bsy[0]), 1);
      end
    end
    val[0] = 1'b0;
    @(negedge clk);
    chk("b2b_ovf_pulse", 32'(ovf[0]), 0);
    chk("b2b_tx17", 32'(txl[0]), 0);
    chk("b2b_busy17", 32'(bsy[0]), 1);
    for (int c = 18; c < 17 * 40; c++) begin
      int j;
      int b;
      logic [9:0] fr;
      j  = c / 40;
      b  = (c % 40) / 4;
      fr = {1'b1, 8'(j), 1'b0};
      @(negedge clk);
      chk("b2b_tx", 32'(txl[0]), 32'(fr[b]));
      chk("b2b_busy", 32'(bsy[0]), 1);
    end
    @(negedge clk);
    chk("b2b_end_busy", 32'(bsy[0]), 0);
    chk("b2b_end_tx", 32'(txl[0]), 1);
    chk("b2b_end_cnt", 32'(cnt[0]), 0);

    // Reset during DATA of the second of three queued words.
    @(negedge clk);
    val[0] = 1'b1;
    dat[0] = 8'h11;
    @(negedge clk);
    dat[0] = 8'h00;
    @(negedge clk);
    dat[0] = 8'h33;
    @(negedge clk);
    val[0] = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_tx", 32'(txl[0]), 0);
    chk("mid_busy", 32'(bsy[0]), 1);
    chk("mid_cnt", 32'(cnt[0]), 1);
    rst = 1'b0;
    #1;
    reset_chk("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      chk("post_tx", 32'(txl[0]), 1);
      chk("post_busy", 32'(bsy[0]), 0);
    end
    send(0, 8'hAC);
    frame_chk(0, 16'({1'b1, 8'hAC, 1'b0}), 10, "post_ac");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
